wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Two-master, one-slave Wishbone (classic, non-pipelined) round-robin arbiter in the wb_clk_i (100 MHz PS) domain.
- Shares the single register-space slave between the boardman UART bridge (master 0) and a second bus master (master 1, e.g. a PS-side AXI-to-WB bridge).
- Grant is held for the whole cyc tenure. Ack, err and rty are routed only to the granted master.

Parameters:
- ADDR_WIDTH, 22, width of the adr buses.
- DATA_WIDTH, 32, width of the dat buses. sel width = DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, stalled-strobe limit. Used only with WB_ARB_TIMEOUT_EN. Legal range 1..65535.

Ports:
- wb_clk_i  input  1  bus clock; all logic on the rising edge.
- wb_rst_i  input  1  synchronous, active-high reset.
- mN_cyc_i, mN_stb_i, mN_we_i  input  1 each  master N (N=0,1) cycle, strobe, write-enable.
- mN_adr_i  input  ADDR_WIDTH  master N address.
- mN_dat_i  input  DATA_WIDTH  master N write data.
- mN_sel_i  input  DATA_WIDTH/8  master N byte selects.
- mN_ack_o, mN_err_o, mN_rty_o  output  1 each  terminations to master N.
- mN_dat_o  output  DATA_WIDTH  read data to master N.
- s_cyc_o, s_stb_o, s_we_o  output  1 each  to slave.
- s_adr_o  output  ADDR_WIDTH  to slave.
- s_dat_o  output  DATA_WIDTH  to slave.
- s_sel_o  output  DATA_WIDTH/8  to slave.
- s_ack_i, s_err_i, s_rty_i  input  1 each  slave terminations.
- s_dat_i  input  DATA_WIDTH  slave read data.
- grant_o  output  2  one-hot current grant {m1,m0}; 2'b00 when idle.
- timeout_o  output  1  one-cycle pulse on bus timeout.

Behaviour:
- State machine (registered): IDLE, GRANT0, GRANT1. Register last_grant (0/1); reset value 1, so m0 wins the first contention.
- Reset:
  - state=IDLE, last_grant=1, timeout counter=0.
  - In the cycle after the reset edge: s_cyc_o=s_stb_o=s_we_o=0, s_adr_o/s_dat_o/s_sel_o=0, all mN_ack/err/rty_o=0, grant_o=0, timeout_o=0.
  - Reset asserted mid-transaction abandons it. No termination is sent to the master.
- IDLE:
  - Only one mN_cyc_i high: next state GRANTN.
  - Both high: grant the master != last_grant.
  - Neither high: stay in IDLE.
  - All s_* outputs are 0 in IDLE.
- GRANTN:
  - s_cyc/stb/we/adr/dat/sel_o = mN_* inputs, combinationally.
  - mN_ack/err/rty_o = s_ack/err/rty_i. mN_dat_o = s_dat_i.
  - The other master sees ack/err/rty=0 and dat_o=0.
- Release: in GRANTN with mN_cyc_i low:
  - last_grant<=N.
  - Other master's cyc high: next state GRANT(other), zero dead cycles.
  - Otherwise: next state IDLE.
- Latency: a request arriving in IDLE reaches the slave one cycle after cyc is first sampled high. Data and termination paths have zero added latency.
- Burst/RMW: a master holding cyc across multiple stb cycles keeps the grant. The other master waits indefinitely; no preemption.
- s_ack_i/s_err_i/s_rty_i high while in IDLE are ignored and not forwarded.
- grant_o is a registered decode of state.
- No combinational path from any s_* input to any s_* output.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter increments each cycle s_cyc_o&s_stb_o is high with s_ack_i|s_err_i|s_rty_i low. It clears on any termination, on release, or in IDLE.
  - When the count reaches TIMEOUT_CYCLES-1 with no termination, the next cycle asserts all of: mN_err_o=1 to the granted master, s_stb_o forced 0, timeout_o=1, counter cleared. Each lasts one cycle.
  - The grant is retained until the master drops cyc.
- Undefined: no counter, timeout_o tied 0, transactions wait indefinitely.

Test Plan:
- m0 single write: adr=0x00010, dat=0x12345678, slave acks 2 cycles after s_stb_o -> s_* mirrors m0 from cycle+1; m0_ack_o 1 cycle; m1_ack_o stays 0; grant_o 01 then 00.
- Both cyc rise in the same cycle after reset -> m0 granted; after m0 drops cyc, GRANT1 next cycle; m1 read returns s_dat_i=0xDEADBEEF on m1_dat_o.
- Alternating contention over 4 rounds with both always requesting -> grant sequence m0,m1,m0,m1.
- m0 holds cyc for 3 stb/ack beats while m1 requests -> m1 not granted until the cycle after m0_cyc_i falls; zero idle cycles between grants.
- wb_rst_i pulsed 1 cycle during a GRANT1 strobe -> next cycle s_cyc_o=0, grant_o=00; next contention grants m0.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks -> m0_err_o and timeout_o pulse once on the 9th stalled cycle; s_stb_o low that cycle. Without the macro -> no err, s_stb_o held.

Source files
------------

// File: rtl/wb_rr_arbiter_if.sv
// wb_rr_arbiter_if
// Wishbone classic bus bundle for one master/slave link.
//   cyc, stb, we, adr, dat_w, sel : master -> slave request
//   dat_r, ack, err, rty          : slave -> master response
// Modports:
//   master : the side that issues cycles (drives cyc/stb/...).
//   slave  : the side that answers cycles (drives ack/err/rty/dat_r).
interface wb_rr_arbiter_if #(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 32
) ();
    logic                      cyc;
    logic                      stb;
    logic                      we;
    logic [ADDR_WIDTH-1:0]     adr;
    logic [DATA_WIDTH-1:0]     dat_w;
    logic [DATA_WIDTH/8-1:0]   sel;
    logic [DATA_WIDTH-1:0]     dat_r;
    logic                      ack;
    logic                      err;
    logic                      rty;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output dat_r, ack, err, rty
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
// Two-master / one-slave Wishbone classic round-robin arbiter. Master 0 is
// the UART bridge, master 1 a second bus master. The grant is held for the
// whole cyc tenure; terminations and read data go only to the granted master.
//
// Ports:
//   wb_clk_i   bus clock, rising edge
//   wb_rst_i   synchronous active-high reset
//   m0, m1     request links from the masters (arbiter is their slave)
//   s          request link to the shared slave (arbiter is its master)
//   grant_o    one-hot current grant {m1,m0}, 2'b00 when idle (registered)
//   timeout_o  one-cycle pulse when a stalled strobe is aborted
//
// Optional feature (macro WB_ARB_TIMEOUT_EN): a stalled-strobe watchdog that
// aborts a strobe left unterminated for TIMEOUT_CYCLES cycles with an err to
// the granted master. Without the macro timeout_o is tied low.
//
// state  | meaning
// IDLE   | no master owns the bus, all slave outputs low
// GRANT0 | master 0 owns the bus until it drops cyc
// GRANT1 | master 1 owns the bus until it drops cyc
module wb_rr_arbiter #(
    parameter int ADDR_WIDTH     = 22,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_rr_arbiter_if.slave    m0,
    wb_rr_arbiter_if.slave    m1,
    wb_rr_arbiter_if.master   s,
    output logic [1:0]        grant_o,
    output logic              timeout_o
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [1:0]  grant_q, grant_d;
    logic        timeout_q;
    logic        bus_cyc, bus_stb;

    // Next-state / round-robin decision
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (m0.cyc && m1.cyc)
                    state_d = last_grant_q ? GRANT0 : GRANT1;
                else if (m0.cyc)
                    state_d = GRANT0;
                else if (m1.cyc)
                    state_d = GRANT1;
            end
            GRANT0: begin
                if (!m0.cyc) begin
                    last_grant_d = 1'b0;
                    state_d      = m1.cyc ? GRANT1 : IDLE;
                end
            end
            GRANT1: begin
                if (!m1.cyc) begin
                    last_grant_d = 1'b1;
                    state_d      = m0.cyc ? GRANT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // grant_o is flopped from the next state so it lines up with state_q
        grant_d = {state_d == GRANT1, state_d == GRANT0};
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
        end
    end

    // Bus steering: the only paths are master->slave and slave->master,
    // selected by registered state, so no slave input reaches a slave output.
    always_comb begin
        bus_cyc  = 1'b0;
        bus_stb  = 1'b0;
        s.we     = 1'b0;
        s.adr    = '0;
        s.dat_w  = '0;
        s.sel    = '0;
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m0.rty   = 1'b0;
        m0.dat_r = '0;
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        m1.rty   = 1'b0;
        m1.dat_r = '0;
        if (state_q == GRANT0) begin
            bus_cyc  = m0.cyc;
            bus_stb  = m0.stb & ~timeout_q;
            s.we     = m0.we;
            s.adr    = m0.adr;
            s.dat_w  = m0.dat_w;
            s.sel    = m0.sel;
            m0.ack   = s.ack;
            m0.err   = s.err | timeout_q;
            m0.rty   = s.rty;
            m0.dat_r = s.dat_r;
        end else if (state_q == GRANT1) begin
            bus_cyc  = m1.cyc;
            bus_stb  = m1.stb & ~timeout_q;
            s.we     = m1.we;
            s.adr    = m1.adr;
            s.dat_w  = m1.dat_w;
            s.sel    = m1.sel;
            m1.ack   = s.ack;
            m1.err   = s.err | timeout_q;
            m1.rty   = s.rty;
            m1.dat_r = s.dat_r;
        end
    end

    assign s.cyc   = bus_cyc;
    assign s.stb   = bus_stb;
    assign grant_o = grant_q;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        timeout_d;
    logic        term, stalled;

    always_comb begin
        term      = s.ack | s.err | s.rty;
        stalled   = bus_cyc & bus_stb & ~term;
        timeout_d = stalled && (cnt_q == CNT_LAST);
        cnt_d     = cnt_q;
        // !bus_cyc covers both idle and the release cycle
        if ((state_q == IDLE) || !bus_cyc || term || timeout_q)
            cnt_d = '0;
        else if (timeout_d)
            cnt_d = '0;
        else if (stalled)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign timeout_q = 1'b0;
`endif

    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;
    localparam int AW  = 22;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_bus ();
    wb_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_bus ();
    wb_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_bus ();
    logic [1:0] grant;
    logic       tmo_o;

    wb_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m0       (m0_bus),
        .m1       (m1_bus),
        .s        (s_bus),
        .grant_o  (grant),
        .timeout_o(tmo_o)
    );

    // stimulus held by the bench
    logic          c [2];
    logic          st[2];
    logic          we[2];
    logic [AW-1:0] adr[2];
    logic [DW-1:0] dat[2];
    logic [SW-1:0] sel[2];
    logic          sack, serr, srty;
    logic [DW-1:0] sdat;

    // reference model: who owns the bus, who had it last, stalled-run length
    int owner;
    int last;
    int run;
    bit tmo_m;

    int n_vec = 0;
    int n_miscmp = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // mode 0: random traffic, 1: heavy contention, 2: m0 strobing into a dead slave
    task automatic drive(input int mode);
        int r;
        for (int i = 0; i < 2; i++) begin
            case (mode)
                1: c[i] = !(owner == i && $urandom_range(0, 2) == 0);
                2: c[i] = (i == 0);
                default: c[i] = c[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
            endcase
            st[i]  = (mode == 2) ? c[i] : (c[i] && $urandom_range(0, 3) != 0);
            we[i]  = 1'($urandom_range(0, 1));
            adr[i] = AW'($urandom);
            dat[i] = $urandom;
            sel[i] = SW'($urandom);
        end
        r    = $urandom_range(0, 5);
        sack = (mode != 2) && (r == 0 || (mode == 1 && r == 3));
        serr = (mode != 2) && (r == 1);
        srty = (mode != 2) && (r == 2);
        sdat = $urandom;
    endtask

    task automatic apply();
        m0_bus.cyc = c[0];  m0_bus.stb = st[0]; m0_bus.we = we[0];
        m0_bus.adr = adr[0]; m0_bus.dat_w = dat[0]; m0_bus.sel = sel[0];
        m1_bus.cyc = c[1];  m1_bus.stb = st[1]; m1_bus.we = we[1];
        m1_bus.adr = adr[1]; m1_bus.dat_w = dat[1]; m1_bus.sel = sel[1];
        s_bus.ack = sack; s_bus.err = serr; s_bus.rty = srty; s_bus.dat_r = sdat;
    endtask

    task automatic check_all();
        logic [2:0]    t0, t1;
        logic [DW-1:0] d0, d1;
        logic          e_cyc, e_stb, e_we;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        logic [1:0]    e_grant;
        e_cyc = 0; e_stb = 0; e_we = 0; e_adr = '0; e_dat = '0; e_sel = '0;
        t0 = 3'b000; t1 = 3'b000; d0 = '0; d1 = '0; e_grant = 2'b00;
        if (owner >= 0) begin
            e_cyc   = c[owner];
            e_stb   = st[owner] && !tmo_m;
            e_we    = we[owner];
            e_adr   = adr[owner];
            e_dat   = dat[owner];
            e_sel   = sel[owner];
            e_grant = (owner == 0) ? 2'b01 : 2'b10;
            if (owner == 0) begin t0 = {sack, serr | tmo_m, srty}; d0 = sdat; end
            else            begin t1 = {sack, serr | tmo_m, srty}; d1 = sdat; end
        end
        check("s_cyc",   64'(s_bus.cyc), 64'(e_cyc));
        check("s_stb",   64'(s_bus.stb), 64'(e_stb));
        check("s_we",    64'(s_bus.we), 64'(e_we));
        check("s_adr",   64'(s_bus.adr), 64'(e_adr));
        check("s_dat",   64'(s_bus.dat_w), 64'(e_dat));
        check("s_sel",   64'(s_bus.sel), 64'(e_sel));
        check("m0_term", 64'({m0_bus.ack, m0_bus.err, m0_bus.rty}), 64'(t0));
        check("m1_term", 64'({m1_bus.ack, m1_bus.err, m1_bus.rty}), 64'(t1));
        check("m0_dat",  64'(m0_bus.dat_r), 64'(d0));
        check("m1_dat",  64'(m1_bus.dat_r), 64'(d1));
        check("grant",   64'(grant), 64'(e_grant));
        check("timeout", 64'(tmo_o), 64'(tmo_m));
    endtask

    // Advance the model by one clock using the stimulus the DUT just sampled.
    task automatic model_step();
        bit term, newt;
        int other;
        if (rst) begin
            owner = -1; last = 1; run = 0; tmo_m = 0;
            return;
        end
        term = sack || serr || srty;
        newt = 0;
        if (owner < 0) begin
            if (c[0] && c[1]) owner = (last == 1) ? 0 : 1;
            else if (c[0])    owner = 0;
            else if (c[1])    owner = 1;
            run = 0;
        end else if (!c[owner]) begin
            last  = owner;
            other = 1 - owner;
            owner = c[other] ? other : -1;
            run   = 0;
        end else if (st[owner] && !tmo_m && !term) begin
            run++;
`ifdef WB_ARB_TIMEOUT_EN
            if (run == TMO) begin
                newt = 1;
                run  = 0;
            end
`endif
        end else if (term || tmo_m) begin
            run = 0;
        end
        tmo_m = newt;
    endtask

    task automatic cycle(input int mode, input bit rst_val);
        @(negedge clk);
        rst = rst_val;
        drive(mode);
        apply();
        #1;
        check_all();
        @(posedge clk);
        model_step();
    endtask

    initial begin
        owner = -1; last = 1; run = 0; tmo_m = 0;
        for (int i = 0; i < 2; i++) begin
            c[i] = 0; st[i] = 0; we[i] = 0; adr[i] = '0; dat[i] = '0; sel[i] = '0;
        end
        sack = 0; serr = 0; srty = 0; sdat = '0;
        rst = 1'b1;
        apply();
        @(posedge clk);
        model_step();
        cycle(0, 1'b1);
        for (int k = 0; k < 300; k++)  cycle(1, 1'b0);
        for (int k = 0; k < 3000; k++) cycle(0, $urandom_range(0, 63) == 0);
        cycle(0, 1'b1);
        for (int k = 0; k < 40; k++)   cycle(2, 1'b0);
        for (int k = 0; k < 300; k++)  cycle(1, $urandom_range(0, 63) == 0);
        for (int k = 0; k < 300; k++)  cycle(0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
